// File: rtl/lvds_8b10b_sender.sv
// lvds_8b10b_sender: framed 8b/10b serializer, K28.5 comma then NUM_BYTES data characters per frame.
// Define LVDS_8B10B_SEND_INVERT_EN to invert o_serial (reset value 1) for P/N-swapped routing.
module lvds_8b10b_sender #(
    parameter int NUM_BYTES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [8*NUM_BYTES-1:0] i_data,
    output logic                   o_serial,
    output logic                   o_data_read
);
    localparam int CW = $clog2(NUM_BYTES + 1);
`ifdef LVDS_8B10B_SEND_INVERT_EN
    localparam logic P_INV = 1'b1;
`else
    localparam logic P_INV = 1'b0;
`endif

    logic [3:0]             r_bit;
    logic [CW-1:0]          r_char;
    logic                   r_rd;
    logic [9:0]             r_shift;
    logic [8*NUM_BYTES-1:0] r_hold;
    logic                   r_serial;

    logic [CW-1:0] w_idx;
    logic [7:0]    w_byte;
    logic [4:0]    w_x;
    logic [2:0]    w_y;
    logic [5:0]    w_6n;
    logic [5:0]    w_6;
    logic [3:0]    w_4n;
    logic [3:0]    w_4;
    logic          w_rd6;
    logic          w_a7;
    logic [9:0]    w_code;
    logic          w_rd_next;
    logic          w_last;

    assign w_idx  = (r_char == '0) ? '0 : r_char - 1'b1;
    assign w_byte = r_hold[8*w_idx +: 8];
    assign w_x    = w_byte[4:0];
    assign w_y    = w_byte[7:5];
    assign w_last = (r_bit == 4'd9) && (r_char == CW'(NUM_BYTES));

    // Tables hold the RD- codes; the RD+ code is the complement where they differ.
    always_comb begin
        w_6n = 6'b000000;
        case (w_x)
            5'd0:  w_6n = 6'b100111;
            5'd1:  w_6n = 6'b011101;
            5'd2:  w_6n = 6'b101101;
            5'd3:  w_6n = 6'b110001;
            5'd4:  w_6n = 6'b110101;
            5'd5:  w_6n = 6'b101001;
            5'd6:  w_6n = 6'b011001;
            5'd7:  w_6n = 6'b111000;
            5'd8:  w_6n = 6'b111001;
            5'd9:  w_6n = 6'b100101;
            5'd10: w_6n = 6'b010101;
            5'd11: w_6n = 6'b110100;
            5'd12: w_6n = 6'b001101;
            5'd13: w_6n = 6'b101100;
            5'd14: w_6n = 6'b011100;
            5'd15: w_6n = 6'b010111;
            5'd16: w_6n = 6'b011011;
            5'd17: w_6n = 6'b100011;
            5'd18: w_6n = 6'b010011;
            5'd19: w_6n = 6'b110010;
            5'd20: w_6n = 6'b001011;
            5'd21: w_6n = 6'b101010;
            5'd22: w_6n = 6'b011010;
            5'd23: w_6n = 6'b111010;
            5'd24: w_6n = 6'b110011;
            5'd25: w_6n = 6'b100110;
            5'd26: w_6n = 6'b010110;
            5'd27: w_6n = 6'b110110;
            5'd28: w_6n = 6'b001110;
            5'd29: w_6n = 6'b101110;
            5'd30: w_6n = 6'b011110;
            5'd31: w_6n = 6'b101011;
        endcase
        w_6   = (r_rd && ($countones(w_6n) != 3 || w_x == 5'd7)) ? ~w_6n : w_6n;
        w_rd6 = r_rd ^ ($countones(w_6n) != 3);
        w_a7  = w_rd6 ? (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14)
                      : (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20);
        w_4n = 4'b0000;
        case (w_y)
            3'd0: w_4n = 4'b1011;
            3'd1: w_4n = 4'b1001;
            3'd2: w_4n = 4'b0101;
            3'd3: w_4n = 4'b1100;
            3'd4: w_4n = 4'b1101;
            3'd5: w_4n = 4'b1010;
            3'd6: w_4n = 4'b0110;
            3'd7: w_4n = w_a7 ? 4'b0111 : 4'b1110;
        endcase
        w_4       = (w_rd6 && ($countones(w_4n) != 2 || w_y == 3'd3)) ? ~w_4n : w_4n;
        w_code    = (r_char == '0) ? (r_rd ? 10'b1100000101 : 10'b0011111010) : {w_6, w_4};
        w_rd_next = (r_char == '0) ? ~r_rd : w_rd6 ^ ($countones(w_4n) != 2);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bit       <= '0;
            r_char      <= '0;
            r_rd        <= 1'b0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_serial    <= P_INV;
            o_data_read <= 1'b0;
        end else begin
            if (r_bit == 4'd0) begin
                r_serial <= w_code[9] ^ P_INV;
                r_shift  <= {w_code[8:0], 1'b0};
                r_rd     <= w_rd_next;
            end else begin
                r_serial <= r_shift[9] ^ P_INV;
                r_shift  <= {r_shift[8:0], 1'b0};
            end
            r_bit <= (r_bit == 4'd9) ? 4'd0 : r_bit + 4'd1;
            if (r_bit == 4'd9)
                r_char <= (r_char == CW'(NUM_BYTES)) ? '0 : r_char + 1'b1;
            o_data_read <= w_last;
            if (o_data_read)
                r_hold <= i_data;
        end
    end

    assign o_serial = r_serial;
endmodule

// File: tb/tb_lvds_8b10b_sender.sv
// tb_lvds_8b10b_sender: directed checks of framing, encoding, strobe timing and async reset
// for lvds_8b10b_sender with NUM_BYTES=2 (default build).
module tb_lvds_8b10b_sender;
    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [15:0] i_data = '0;
    logic        o_serial;
    logic        o_data_read;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_pulse = 0;
    int rds = -1;
    int rds_max = 0;

    lvds_8b10b_sender #(.NUM_BYTES(2)) dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_data(i_data),
        .o_serial(o_serial),
        .o_data_read(o_data_read)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_bit(output logic b);
        @(posedge i_clk);
        @(negedge i_clk);
        b = o_serial;
        cyc++;
        rds += b ? 1 : -1;
        if ((rds < 0 ? -rds : rds) > rds_max) rds_max = (rds < 0 ? -rds : rds);
        if (o_data_read) begin
            check("pulse_gap", cyc - last_pulse, 30);
            last_pulse = cyc;
        end
    endtask

    task automatic rd_char(input string tag, input logic [9:0] exp, input logic strobe);
        logic [9:0] c;
        logic b;
        c = '0;
        for (int i = 0; i < 10; i++) begin
            rd_bit(b);
            c = {c[8:0], b};
            check({tag, "_strobe"}, o_data_read, strobe && i == 9);
        end
        check(tag, c, exp);
    endtask

    task automatic rd_frame(input string tag, input logic [9:0] k, input logic [9:0] d0, input logic [9:0] d1);
        rd_char({tag, "_k"}, k, 1'b0);
        rd_char({tag, "_b0"}, d0, 1'b0);
        rd_char({tag, "_b1"}, d1, 1'b1);
    endtask

    task automatic release_rst();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        cyc = 0;
        last_pulse = 0;
        rds = -1;
    endtask

    initial begin
        logic [9:0] p;
        logic b;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            check("rst_serial", o_serial, 0);
            check("rst_read", o_data_read, 0);
        end
        release_rst();
        i_data = 16'h0001;
        rd_frame("f1", 10'b0011111010, 10'b0110001011, 10'b0110001011);
        rd_frame("f2", 10'b1100000101, 10'b0111010100, 10'b1001110100);
        rd_frame("f3", 10'b0011111010, 10'b1000101011, 10'b0110001011);
        i_data = 16'habcd;
        rd_frame("f4", 10'b1100000101, 10'b1011000110, 10'b1101001010);
        rd_frame("f5", 10'b0011111010, 10'b1011000110, 10'b1101001010);
        rd_char("f6_k", 10'b1100000101, 1'b0);
        p = '0;
        for (int i = 0; i < 7; i++) begin
            rd_bit(b);
            p = {p[8:0], b};
        end
        check("f6_partial", p, 10'b0001011000);
        @(posedge i_clk);
        #2;
        check("pre_reset_bit17", o_serial, 1);
        i_reset_n = 1'b0;
        #1;
        check("async_serial", o_serial, 0);
        check("async_read", o_data_read, 0);
        repeat (3) @(negedge i_clk);
        check("held_serial", o_serial, 0);
        release_rst();
        rd_frame("f7", 10'b0011111010, 10'b0110001011, 10'b0110001011);
        check("rds_within_3", rds_max <= 3, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
